// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - launches a selected InstROM program and supervises it to halt or timeout

module run_sequencer #(
  parameter int PC_W        = 10,
  parameter int CNT_W       = 16,
  parameter int NUM_PROGS   = 3,
  parameter int PROG_BASE_0 = 0,
  parameter int PROG_BASE_1 = 128,
  parameter int PROG_BASE_2 = 256,
  parameter int PROG_BASE_3 = 384,
  parameter int START_HOLD  = 2,
  parameter int MAX_CYCLES  = 4095
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic [1:0]       prog_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             err_sel_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             core_start_o,
  output logic [PC_W-1:0]  core_target_o,
  input  logic             core_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int               HOLD_W    = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [2:0]        NUM_SEL   = 3'(NUM_PROGS);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_q, timeout_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic               err_sel_q, err_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_q, start_d;

  logic sel_ok;
  logic hold_done;
  logic limit_hit;

  assign sel_ok    = ({1'b0, prog_sel_i} < NUM_SEL);
  assign hold_done = (hold_q == HOLD_LAST);
  assign limit_hit = (count_q == CNT_LAST);

  function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
    case (sel)
      2'd0:    base_of = PC_W'(PROG_BASE_0);
      2'd1:    base_of = PC_W'(PROG_BASE_1);
      2'd2:    base_of = PC_W'(PROG_BASE_2);
      default: base_of = PC_W'(PROG_BASE_3);
    endcase
  endfunction

  // State and registered outputs; reset drops any launch or run in flight without a Done
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      target_q  <= PC_W'(PROG_BASE_0);
      err_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      target_q  <= target_d;
      err_sel_q <= err_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

  // Next state: launch on a valid request, leave LAUNCH after the hold, end RUN on Ack or limit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_i && sel_ok) state_d = S_LAUNCH;
      S_LAUNCH: if (hold_done) state_d = S_RUN;
      S_RUN:    if (core_ack_i || limit_hit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next values; Ack is only honoured in RUN, so a stale Ack during LAUNCH is dropped
  always_comb begin
    hold_d    = hold_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    target_d  = target_q;
    err_sel_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (sel_ok) begin
            target_d  = base_of(prog_sel_i);
            count_d   = '0;
            timeout_d = 1'b0;
            hold_d    = '0;
          end else begin
            err_sel_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (!hold_done) hold_d = hold_q + 1'b1;
      end
      S_RUN: begin
        if (!core_ack_i) begin
          count_d = count_q + 1'b1;
          if (limit_hit) timeout_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
    start_d = (state_d == S_LAUNCH);
    busy_d  = (state_d == S_LAUNCH) || (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign err_sel_o     = err_sel_q;
  assign cycle_count_o = count_q;
  assign core_start_o  = start_q;
  assign core_target_o = target_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer against a behavioural model

module tb_run_sequencer;

  localparam int PC_W       = 10;
  localparam int CNT_W      = 16;
  localparam int NUM_PROGS  = 3;
  localparam int START_HOLD = 2;
  localparam int MAX_CYCLES = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic             ack = 1'b0;
  logic             busy, done, timeout, err_sel, start;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  target;

  run_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .NUM_PROGS(NUM_PROGS),
    .PROG_BASE_0(0), .PROG_BASE_1(128), .PROG_BASE_2(256), .PROG_BASE_3(384),
    .START_HOLD(START_HOLD), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk_i(clk), .reset_i(rst), .req_i(req), .prog_sel_i(sel),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .err_sel_o(err_sel),
    .cycle_count_o(count), .core_start_o(start), .core_target_o(target),
    .core_ack_i(ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: launch cycles remaining, running flag, pending done pulse
  int base_tbl[4] = '{0, 128, 256, 384};
  int m_launch_left = 0;
  bit m_running = 0;
  bit m_done = 0;
  bit m_timeout = 0;
  bit m_err = 0;
  int m_count = 0;
  int m_target = 0;

  always @(posedge clk) begin
    m_err = 0;
    if (rst) begin
      m_launch_left = 0; m_running = 0; m_done = 0;
      m_timeout = 0; m_count = 0; m_target = base_tbl[0];
    end else if (m_done) begin
      m_done = 0;
    end else if (m_running) begin
      if (ack) begin
        m_running = 0; m_done = 1;
      end else begin
        m_count++;
        if (m_count == MAX_CYCLES) begin
          m_timeout = 1; m_running = 0; m_done = 1;
        end
      end
    end else if (m_launch_left > 0) begin
      m_launch_left--;
      if (m_launch_left == 0) m_running = 1;
    end else if (req) begin
      if (int'(sel) < NUM_PROGS) begin
        m_launch_left = START_HOLD;
        m_target = base_tbl[sel];
        m_count = 0;
        m_timeout = 0;
      end else begin
        m_err = 1;
      end
    end
  end

  bit cmp_en = 1;

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    32'(busy),    32'(m_launch_left > 0 || m_running));
      chk("start",   32'(start),   32'(m_launch_left > 0));
      chk("done",    32'(done),    32'(m_done));
      chk("timeout", 32'(timeout), 32'(m_timeout));
      chk("err_sel", 32'(err_sel), 32'(m_err));
      chk("count",   32'(count),   32'(m_count));
      chk("target",  32'(target),  32'(m_target));
    end
  end

  task automatic launch(input logic [1:0] s);
    req = 1'b1; sel = s;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int k = 0;
    while (start !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_run_bound"}, 32'(k < 20), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk({tag, "_done_bound"}, 32'(k < 100), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_start", 32'(start), 32'd0);

    // Program 1 launch: target 128, start held exactly two cycles
    launch(2'd1);
    chk("t1_target", 32'(target), 32'd128);
    chk("t1_busy", 32'(busy), 32'd1);
    n = 0;
    while (start === 1'b1 && n < 10) begin n++; @(negedge clk); end
    chk("t1_start_hold", 32'(n), 32'd2);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(count), 32'd0);
    @(negedge clk);

    // Program 0, ack after ten run cycles
    launch(2'd0);
    wait_run("t2");
    repeat (10) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd10);
    chk("t2_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("t2_done_once", 32'(done), 32'd0);

    // Program 2, never acked: timeout at the limit, held afterwards
    launch(2'd2);
    wait_done("t3");
    chk("t3_count", 32'(count), 32'd20);
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_target", 32'(target), 32'd256);
    repeat (5) @(negedge clk);
    chk("t3_timeout_held", 32'(timeout), 32'd1);
    chk("t3_count_held", 32'(count), 32'd20);

    // Invalid selector: error pulse only
    launch(2'd3);
    chk("t4_err", 32'(err_sel), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_start", 32'(start), 32'd0);
    chk("t4_timeout_kept", 32'(timeout), 32'd1);
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_sel), 32'd0);
    chk("t4_start2", 32'(start), 32'd0);

    // Req held through a run, stale ack in LAUNCH, back-to-back relaunch
    req = 1'b1; sel = 2'd0;
    @(negedge clk);
    ack = 1'b1;
    wait_run("t5");
    ack = 1'b0;
    repeat (3) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_count", 32'(count), 32'd3);
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_relaunch", 32'(start), 32'd1);
    chk("t5_count_clr", 32'(count), 32'd0);
    req = 1'b0;
    wait_run("t5b");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);

    // Reset mid-run
    launch(2'd1);
    wait_run("t6");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_start", 32'(start), 32'd0);
    chk("t6_target", 32'(target), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
    end

    // Randomised traffic checked by the every-cycle compare
    repeat (3000) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      ack = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; req = 1'b0; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
